// File: rtl/mod_fifo_n.sv
// -----------------------------------------------------------------------------
// mod_fifo_n
//
// Parametrised synchronous FIFO for the AES256 datapath. Buffers WIDTH-bit
// words between a producer (ROM / S-box stage) and a consumer (16-byte state
// register). Successor to the single-entry byte buffer: configurable depth,
// full / count / almost-full status, simultaneous push and pop, and optional
// sticky error flags.
//
// Optional feature macro: FIFO_ERR_FLAGS_EN
//   defined   -> ports ovf, udf, err_clr exist (sticky overflow/underflow flags)
//   undefined -> those ports are absent; dropped writes and empty reads are silent
//
// Parameters
//   WIDTH     data word width in bits (>= 1)
//   DEPTH     number of storage entries (>= 2, any integer, not only powers of 2)
//   AF_LEVEL  almost_full asserts when count >= AF_LEVEL (1..DEPTH)
//
// Ports
//   clk          in   1      single clock, rising edge
//   resetn       in   1      asynchronous active-low reset
//   wr_en        in   1      push request
//   wr_data      in   WIDTH  push data
//   rd_en        in   1      pop request
//   rd_data      out  WIDTH  registered pop data, holds between pops
//   empty        out  1      count == 0
//   full         out  1      count == DEPTH
//   almost_full  out  1      count >= AF_LEVEL
//   count        out  CW     occupancy 0..DEPTH, CW = $clog2(DEPTH+1)
//   ovf          out  1      sticky overflow flag      (FIFO_ERR_FLAGS_EN only)
//   udf          out  1      sticky underflow flag     (FIFO_ERR_FLAGS_EN only)
//   err_clr      in   1      synchronous clear of ovf/udf (FIFO_ERR_FLAGS_EN only)
// -----------------------------------------------------------------------------
module mod_fifo_n #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic [CW-1:0]    count
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic             ovf,
  output logic             udf,
  input  logic             err_clr
`endif
);

  localparam int AW = $clog2(DEPTH);

  // Pointer advance with an explicit wrap compare, so non-power-of-2 depths
  // never index past the last entry.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
    if (ptr == AW'(DEPTH - 1)) begin
      return '0;
    end
    return ptr + AW'(1);
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;
  logic [CW-1:0]    count_nxt;

  // A push into a full FIFO is accepted only when a pop frees a slot in the
  // same cycle. A pop never sees the word being pushed this cycle (no
  // fall-through), because pop_ok looks at the registered empty flag.
  always_comb begin
    push_ok   = wr_en && (!full || rd_en);
    pop_ok    = rd_en && !empty;
    count_nxt = count + CW'(push_ok) - CW'(pop_ok);
  end

  // Storage is not reset; only pointers and status decide what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, count, read data and status flags. Flags are computed from the
  // next count so they change on the same edge as count itself.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      rd_data     <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop_ok) begin
        rd_ptr  <= ptr_inc(rd_ptr);
        rd_data <= mem[rd_ptr];
      end
      count       <= count_nxt;
      empty       <= (count_nxt == '0);
      full        <= (count_nxt == CW'(DEPTH));
      almost_full <= (count_nxt >= CW'(AF_LEVEL));
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  // Sticky error flags; a clear in the same cycle as a new error wins.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else if (err_clr) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (wr_en && !push_ok) begin
        ovf <= 1'b1;
      end
      if (rd_en && empty) begin
        udf <= 1'b1;
      end
    end
  end
`endif

endmodule
